uart_tx: RTL

UART transmitter that serialises one byte per frame onto tx_o: start bit, 8 data bits LSB first, optional parity, then 1 or 2 stop bits.
It is the transmit-side counterpart of the existing receiver and shares its bit timing (CLKS_PER_BIT clocks per bit).
It sits between a byte producer (valid/ready handshake) and the board TX pin.
The two blocks are paired in loopback benches.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_tx_if.sv | 9 +
 rtl/uart_baud_timer.sv | 30 +++
 rtl/uart_tx.sv | 135 +++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings, parity modes and the parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } uart_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    localparam int CLKS_PER_BIT_DEFAULT = 868;

    function automatic logic parity_bit(input logic [7:0] d, input int mode);
        return (mode == PARITY_ODD) ? ~^d : ^d;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the UART transmitter.
interface uart_tx_if;
    logic [7:0] d_i;
    logic       valid_i;
    logic       ready_o;

    modport master (output d_i, output valid_i, input ready_o);
    modport slave  (input d_i, input valid_i, output ready_o);
endinterface

// File: rtl/uart_baud_timer.sv
// Per-bit down counter; bit_end marks the last clock of the current bit.
module uart_baud_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic bit_end
);

    localparam int TW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [TW-1:0] LOAD_VAL = TW'(CLKS_PER_BIT);

    logic [TW-1:0] timer_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q <= LOAD_VAL;
        end else if (load) begin
            timer_q <= LOAD_VAL;
        end else begin
            timer_q <= timer_q - TW'(1);
        end
    end

    assign bit_end = (timer_q == TW'(1));

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB first, optional parity, 1 or 2 stops.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int PARITY       = PARITY_NONE,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    uart_tx_if.slave   bus,
    output logic       tx_o,
    output logic       busy_o,
    output logic       done_o
);

    if (CLKS_PER_BIT < 2 || PARITY < 0 || PARITY > 2 ||
        (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_params
        $error("uart_tx: illegal parameter combination");
    end

    uart_state_t state_q, state_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [2:0]  idx_q, idx_d;
    logic        par_q, par_d;
    logic        stop2_q, stop2_d;
    logic        tx_q, tx_d;
    logic        done;
    logic        bit_end;
    logic        accept;
    logic        last_stop;

    // Timer is parked at full count while idle so the start bit gets a full period.
    uart_baud_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   ((state_q == S_IDLE) || bit_end),
        .bit_end(bit_end)
    );

    assign bus.ready_o = (state_q == S_IDLE) && !reset;
    assign accept      = bus.valid_i && bus.ready_o;
    assign last_stop   = (STOP_BITS == 1) || stop2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            par_q   <= 1'b0;
            stop2_q <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            par_q   <= par_d;
            stop2_q <= stop2_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        par_d   = par_q;
        stop2_d = stop2_q;
        tx_d    = tx_q;
        done    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (accept) begin
                    shreg_d = bus.d_i;
                    par_d   = parity_bit(bus.d_i, PARITY);
                    idx_d   = '0;
                    stop2_d = 1'b0;
                    state_d = S_START;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    tx_d    = shreg_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shreg_d = {1'b0, shreg_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    tx_d    = shreg_q[1];
                    if (idx_q == 3'd7) begin
                        if (PARITY != PARITY_NONE) begin
                            state_d = S_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
            S_STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    if (last_stop) begin
                        done    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        stop2_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign tx_o   = tx_q;
    assign busy_o = (state_q != S_IDLE);
    assign done_o = done;

endmodule
